// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle add/sub/logic/compare, iterative shift-add multiply
// and restoring divide behind a start/busy/done handshake with registered results.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is taken on a rising edge only while busy=0 (IDLE or DONE);
  // done pulses for one cycle and result outputs stay valid until the next completion.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;

  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_dbz;
  logic             start_iter;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH:0]   mul_sum, shifted;
  logic [WIDTH-1:0] it_hi, it_lo;

  assign state_dbg = state;

  // Single-cycle results, computed straight from the operands on the accept edge.
  always_comb begin
    sc_res   = '0;
    sc_hi    = '0;
    sc_dbz   = 1'b0;
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    case (op)
      3'b000: begin
        sc_res = sum_ext[WIDTH-1:0];
        sc_hi  = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH]};
      end
      3'b001: begin
        sc_res = diff_ext[WIDTH-1:0];
        sc_hi  = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
      end
      3'b010: sc_res = a & b;
      3'b011: sc_res = a | b;
      3'b100: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      3'b101: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b110: sc_res = '0;
      3'b111: begin
        sc_res = '1;
        sc_hi  = a;
        sc_dbz = 1'b1;
      end
    endcase
  end

  assign start_iter = (op == 3'b110) || ((op == 3'b111) && (b != '0));

  // One iteration step. Multiply: hi_q is the partial product, lo_q the shifting
  // multiplier. Divide: hi_q is the partial remainder, lo_q the shifting dividend/quotient.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    if (is_div) begin
      if (shifted >= {1'b0, opnd_q}) begin
        it_hi = shifted[WIDTH-1:0] - opnd_q;
        it_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        it_hi = shifted[WIDTH-1:0];
        it_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      is_div      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (start_iter) begin
              state  <= RUN;
              busy   <= 1'b1;
              cnt    <= CW'(WIDTH);
              is_div <= op[0];
              hi_q   <= '0;
              lo_q   <= a;
              opnd_q <= b;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              result      <= sc_res;
              result_hi   <= sc_hi;
              zero        <= (sc_res == '0);
              div_by_zero <= sc_dbz;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          hi_q <= it_hi;
          lo_q <= it_lo;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            result      <= it_lo;
            result_hi   <= it_hi;
            zero        <= (it_lo == '0);
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised and directed bench for alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int W = 16;
  localparam int ITER_LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, zero, div_by_zero;
  logic [W-1:0] result, result_hi;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_hi_q[$];

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .div_by_zero(div_by_zero), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model: plain arithmetic on wide integers.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [W-1:0] h,
                       output logic dz, output int lat);
    longint unsigned xs, ys, p;
    xs = x; ys = y;
    r = '0; h = '0; dz = 1'b0; lat = 1;
    case (o)
      3'd0: begin p = xs + ys; r = W'(p); h = W'(p >> W); end
      3'd1: begin r = W'(xs - ys); h = (xs < ys) ? W'(1) : W'(0); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = (xs < ys) ? W'(1) : W'(0);
      3'd5: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      3'd6: begin p = xs * ys; r = W'(p); h = W'(p >> W); lat = ITER_LAT; end
      3'd7: begin
        if (ys == 0) begin r = '1; h = x; dz = 1'b1; end
        else begin r = W'(xs / ys); h = W'(xs % ys); lat = ITER_LAT; end
      end
    endcase
  endtask

  // Issues one op (called at #1 after an edge) and waits for done. With poke set,
  // an add request is pulsed mid-iteration and must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit poke);
    logic [W-1:0] er, eh, pr;
    logic ed;
    int el, lat, busy_n;
    bit held;
    model(o, x, y, er, eh, ed, el);
    exp_q.push_back(er);
    exp_hi_q.push_back(eh);
    pr = result;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom_range(0, 7));
    lat = 1; busy_n = 0; held = 1'b1;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      if (result !== pr) held = 1'b0;
      if (poke && lat == 5) begin start = 1'b1; op = 3'd0; a = 16'h0001; b = 16'h0001; end
      else if (poke && lat == 6) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, el);
    check({tag, "_busy_cycles"}, busy_n, (el == ITER_LAT) ? W : 0);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_held"}, held, 1);
    check({tag, "_result"}, result, exp_q.pop_front());
    check({tag, "_result_hi"}, result_hi, exp_hi_q.pop_front());
    check({tag, "_zero"}, zero, (er == '0));
    check({tag, "_dbz"}, div_by_zero, ed);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_result"}, result, 0);
    check({tag, "_result_hi"}, result_hi, 0);
    check({tag, "_zero"}, zero, 1);
    check({tag, "_dbz"}, div_by_zero, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [W-1:0] r1, h1, r2, h2, pr;
    logic dz;
    int lat, gap;
    bit saw_done, held;

    #12;
    check_reset_values("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    check("done_pulse_width", done, 0);
    run_op("slt", 3'd5, 16'hFFFF, 16'h0001, 1'b0);
    run_op("sltu", 3'd4, 16'hFFFF, 16'h0001, 1'b0);
    run_op("sub", 3'd1, 16'h0003, 16'h0005, 1'b0);
    run_op("mulu", 3'd6, 16'h1234, 16'h5678, 1'b0);
    run_op("divu", 3'd7, 16'd100, 16'd7, 1'b0);
    run_op("divu_zero", 3'd7, 16'h00AB, 16'h0000, 1'b0);
    run_op("mulu_poke", 3'd6, 16'hBEEF, 16'h0123, 1'b1);
    run_op("divu_max", 3'd7, 16'hFFFF, 16'h0001, 1'b0);
    run_op("mulu_max", 3'd6, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("divu_zero_before", 3'd7, 16'h1234, 16'h0000, 1'b0);

    // Reset in the middle of a multiply: outputs return to reset values, no done.
    op = 3'd6; a = 16'h0F0F; b = 16'h0303; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; reset = 1'b1; #1;
    check_reset_values("mid_reset");
    @(negedge clk); reset = 1'b0;
    saw_done = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("mid_reset_no_done", saw_done, 0);

    // start held high: second multiply accepted in the first one's DONE cycle.
    model(3'd6, 16'h00FF, 16'h0101, r1, h1, dz, lat);
    model(3'd6, 16'hA5A5, 16'h3C3C, r2, h2, dz, lat);
    op = 3'd6; a = 16'h00FF; b = 16'h0101; start = 1'b1;
    @(posedge clk); #1;
    a = 16'hA5A5; b = 16'h3C3C;
    lat = 1;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("b2b_first_latency", lat, ITER_LAT);
    check("b2b_first_result", result, r1);
    check("b2b_first_hi", result_hi, h1);
    pr = result;
    @(posedge clk); #1;
    start = 1'b0;
    gap = 1; held = 1'b1;
    while (!done && gap < 100) begin
      if (result !== pr) held = 1'b0;
      @(posedge clk); #1; gap++;
    end
    check("b2b_gap", gap, ITER_LAT);
    check("b2b_held", held, 1);
    check("b2b_second_result", result, r2);
    check("b2b_second_hi", result_hi, h2);
    @(posedge clk); #1;

    // Random ops, some back-to-back from DONE, divide-by-zero mixed in.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      run_op($sformatf("rnd%0d", i), ro, ra, rb, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
